// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: CPU data-memory port as seen from the MEM stage.
//   addr       : byte address
//   write_data : store data
//   mem_read   : one-cycle load strobe
//   mem_write  : one-cycle store strobe
//   read_data  : combinational load response from the peripheral
// master = CPU side, slave = peripheral side.
interface mmio_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] read_data;

  modport master (output addr, write_data, mem_read, mem_write, input read_data);
  modport slave  (input addr, write_data, mem_read, mem_write, output read_data);
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter.
//   TXDATA at BASE_ADDR+0 (store pushes a byte, load reads 0)
//   STATUS at BASE_ADDR+4 (load: {overflow, fifo_empty, fifo_full, busy};
//                          store with bit3 set clears overflow)
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : data-memory port (slave modport), read_data is combinational
//   o_tx       : registered serial line, idle high
// Build option: define UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO;
// without it a single holding register buffers one byte.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0080,
  parameter int          CLKS_PER_BIT = 234,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           o_tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          overflow;

  logic       sel_data, sel_stat;
  logic       push_req, push_ok, ovf_set, pop;
  logic       fifo_empty, fifo_full, busy, baud_done;
  logic [7:0] head;

  assign sel_data  = (bus.addr == BASE_ADDR);
  assign sel_stat  = (bus.addr == BASE_ADDR + 32'd4);
  assign push_req  = bus.mem_write & sel_data;
  assign baud_done = (baud == BW'(CLKS_PER_BIT - 1));
  assign busy      = (state != IDLE);

  // The serializer pulls a byte either when idle or at the last cycle of a
  // stop bit, which is what makes back-to-back frames gapless.
  assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_done));

  // A pop on the same edge frees a slot, so a store into a full buffer is
  // still accepted in that case.
  assign push_ok = push_req && (!fifo_full || pop);
  assign ovf_set = push_req && fifo_full && !pop;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          unused_ok;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign head       = mem[rd_ptr];
  assign unused_ok  = ^bus.write_data[31:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= bus.write_data[7:0];
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
`else
  logic [7:0] hold;
  logic       hold_vld;
  logic       unused_ok;

  assign fifo_empty = !hold_vld;
  assign fifo_full  = hold_vld;
  assign head       = hold;
  assign unused_ok  = ^{bus.write_data[31:8], 32'(FIFO_DEPTH)};

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vld <= 1'b0;
    end else if (push_ok) begin
      hold     <= bus.write_data[7:0];
      hold_vld <= 1'b1;
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (bus.mem_write && sel_stat && bus.write_data[3]) begin
      overflow <= 1'b0;
    end
  end

  assign bus.read_data = (bus.mem_read && sel_stat) ?
                         {28'b0, overflow, fifo_empty, fifo_full, busy} : 32'b0;

  // o_tx is registered and always assigned the level of the state being
  // entered, so the line changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      o_tx    <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_tx <= 1'b1;
          if (pop) begin
            shift   <= head;
            baud    <= '0;
            bit_idx <= '0;
            state   <= START;
            o_tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud  <= '0;
            state <= DATA;
            o_tx  <= shift[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              o_tx  <= 1'b1;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
              o_tx    <= shift[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud <= '0;
            if (pop) begin
              shift   <= head;
              bit_idx <= '0;
              state   <= START;
              o_tx    <= 1'b0;
            end else begin
              state <= IDLE;
              o_tx  <= 1'b1;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          o_tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx. Accepted bytes go into a
// scoreboard queue; a line monitor checks every cycle of every frame against
// the head of the queue and pops it at the end of the stop bit.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h0000_0080;
  localparam logic [31:0] STAT = BASE + 32'd4;
  localparam int          CPB  = 4;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic o_tx;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .o_tx(o_tx)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line monitor
  bit         m_act = 1'b0;
  int         m_cyc = 0;
  logic [7:0] m_exp = 8'h0;
  int         idle_cnt = 1;
  int         contig = 0;

  always @(negedge clk) begin
    if (reset) begin
      m_act    = 1'b0;
      idle_cnt = 1;
    end else begin
      if (!m_act) begin
        if (o_tx === 1'b0) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_frame", 32'(o_tx), 32'd1);
          end else begin
            m_exp = sb_q[0];
            m_act = 1'b1;
            m_cyc = 0;
            if (idle_cnt == 0) contig++;
          end
        end else begin
          idle_cnt++;
        end
      end
      if (m_act) begin
        int   idx;
        logic eb;
        idx = m_cyc / CPB;
        eb  = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : m_exp[idx-1];
        chk("frame_bit", 32'(o_tx), 32'(eb));
        if (m_cyc == 10*CPB - 1) begin
          void'(sb_q.pop_front());
          m_act    = 1'b0;
          idle_cnt = 0;
        end else begin
          m_cyc++;
        end
      end
    end
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit push);
    bus.addr       = a;
    bus.write_data = d;
    bus.mem_write  = 1'b1;
    if (push) sb_q.push_back(d[7:0]);
    @(posedge clk); #1;
    bus.mem_write  = 1'b0;
    bus.addr       = 32'h0;
    bus.write_data = 32'h0;
  endtask

  task automatic read_at(input logic [31:0] a, output logic [31:0] v);
    bus.addr     = a;
    bus.mem_read = 1'b1;
    @(negedge clk);
    v = bus.read_data;
    bus.mem_read = 1'b0;
    bus.addr     = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    logic [31:0] v;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      read_at(STAT, v);
      if (sb_q.size() == 0 && v[0] == 1'b0) done = 1'b1;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    logic [31:0] v;
    int bcnt, c0;
    bus.addr = 32'h0; bus.write_data = 32'h0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;

    // Reset state
    ticks(3);
    read_at(STAT, v);
    chk("stat_in_reset", v, 32'h4);
    chk("otx_in_reset", 32'(o_tx), 32'd1);
    reset = 1'b0;
    ticks(1);
    read_at(STAT, v);
    chk("stat_after_reset", v, 32'h4);
    chk("otx_after_reset", 32'(o_tx), 32'd1);

    // Single frame 0x55, busy for exactly 10*CPB cycles
    store(BASE, 32'h55, 1'b1);
    bcnt = 0;
    for (int i = 0; i < 60; i++) begin
      read_at(STAT, v);
      if (v[0]) bcnt++;
    end
    chk("busy_cycles", 32'(bcnt), 32'(10*CPB));
    chk("stat_idle", v, 32'h4);
    chk("sb_after_55", 32'(sb_q.size()), 32'd0);

    // Three gapless frames; third byte arrives while the second is on the line
    c0 = contig;
    store(BASE, 32'h01, 1'b1);
    store(BASE, 32'h02, 1'b1);
    ticks(45);
    store(BASE, 32'h03, 1'b1);
    ticks(45);
    read_at(STAT, v);
    chk("stat_last_frame", v, 32'h5);
    drain("drain_123");
    chk("gapless", 32'(contig - c0), 32'd2);

    // Overflow: one byte in flight, fill the buffer, one more is dropped
    store(BASE, 32'hA5, 1'b1);
    ticks(2);
    for (int i = 0; i < DEPTH + 1; i++) store(BASE, 32'h10 + 32'(i), (i < DEPTH));
    read_at(STAT, v);
    chk("stat_overflow", v, 32'hB);
    store(STAT, 32'h07, 1'b0);
    read_at(STAT, v);
    chk("ovf_sticky", v, 32'hB);
    store(STAT, 32'h08, 1'b0);
    read_at(STAT, v);
    chk("ovf_cleared", v, 32'h3);
    drain("drain_ovf");
    read_at(STAT, v);
    chk("stat_after_ovf", v, 32'h4);

    // Reset in the middle of a data bit
    store(BASE, 32'h0F, 1'b1);
    ticks(10);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("otx_abort", 32'(o_tx), 32'd1);
    read_at(STAT, v);
    chk("stat_abort", v, 32'h4);
    sb_q.delete();
    reset = 1'b0;
    ticks(2);
    store(BASE, 32'h3C, 1'b1);
    drain("drain_after_abort");

    // Address decode
    store(32'h0000_007A, 32'h99, 1'b0);
    store(BASE + 32'd8, 32'h99, 1'b0);
    read_at(32'h0000_007A, v);
    chk("rd_7a", v, 32'h0);
    read_at(BASE + 32'd8, v);
    chk("rd_base8", v, 32'h0);
    read_at(BASE, v);
    chk("rd_txdata", v, 32'h0);
    bus.addr = STAT;
    @(negedge clk);
    chk("rd_no_strobe", bus.read_data, 32'h0);
    bus.addr = 32'h0;
    ticks(5);
    read_at(STAT, v);
    chk("stat_decode", v, 32'h4);
    chk("sb_final", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
